// File: rtl/lock_pkg.sv
// Shared keypad/lock definitions: key codes, encoder state encoding and the
// row/column to key-code mapping.
package lock_pkg;

  localparam logic [3:0] KEY_0    = 4'b0000;
  localparam logic [3:0] KEY_1    = 4'b0001;
  localparam logic [3:0] KEY_2    = 4'b0010;
  localparam logic [3:0] KEY_3    = 4'b0011;
  localparam logic [3:0] KEY_4    = 4'b0100;
  localparam logic [3:0] KEY_5    = 4'b0101;
  localparam logic [3:0] KEY_6    = 4'b0110;
  localparam logic [3:0] KEY_7    = 4'b0111;
  localparam logic [3:0] KEY_8    = 4'b1000;
  localparam logic [3:0] KEY_9    = 4'b1001;
  localparam logic [3:0] KEY_STAR = 4'b1010;
  localparam logic [3:0] KEY_HASH = 4'b1011;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  // Rows 0-2 hold digits 1-9 in reading order; row 3 is "* 0 #".
  function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = KEY_0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Scan timebase: divider producing the row-sample strobe, plus the driven
// column index which steps only on a sample cycle when asked to.
module keypad_scan_tick #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset_1,
  input  logic       col_advance,
  output logic       sample,
  output logic [1:0] col_idx
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic [1:0]       col_reg;

  assign sample  = (div_reg == DIV_LAST);
  assign col_idx = col_reg;

  always_ff @(posedge clk) begin
    if (!reset_1) begin
      div_reg <= '0;
      col_reg <= 2'd0;
    end else begin
      div_reg <= sample ? '0 : div_reg + DIV_W'(1);
      if (sample && col_advance)
        col_reg <= (col_reg == 2'd2) ? 2'd0 : col_reg + 2'd1;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// 4x3 matrix keypad scanner: debounces a single pressed key, emits one
// Code_1/Valid_1 pulse per press and waits for a debounced release.
module keypad_encoder
  import lock_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 8
) (
  input  logic       clk,
  input  logic       reset_1,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] Code_1,
  output logic       Valid_1,
  output logic       key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N);

  kp_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [1:0]       cand_row_reg, cand_row_next;
  logic [1:0]       cand_col_reg, cand_col_next;
  logic [3:0]       code_reg, code_next;
  logic             valid_reg, valid_next;
  logic             held_reg, held_next;

  logic             sample, col_advance;
  logic [1:0]       col_idx, row_hit;
  logic [3:0]       single_low;
  logic             cand_match;

  keypad_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk         (clk),
    .reset_1     (reset_1),
    .col_advance (col_advance),
    .sample      (sample),
    .col_idx     (col_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      localparam logic [3:0] ROW_MASK = 4'b0001 << gi;
      assign single_low[gi] = (row_n == ~ROW_MASK);
    end
    for (gi = 0; gi < 3; gi++) begin : g_col
      assign col_n[gi] = (col_idx != 2'(gi));
    end
  endgenerate

  assign row_hit    = single_low[3] ? 2'd3 : single_low[2] ? 2'd2 : single_low[1] ? 2'd1 : 2'd0;
  assign cand_match = (row_n == ~(4'b0001 << cand_row_reg));
  assign cnt_inc    = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_1) begin
      state_reg    <= SCAN;
      cnt_reg      <= '0;
      cand_row_reg <= 2'd0;
      cand_col_reg <= 2'd0;
      code_reg     <= KEY_0;
      valid_reg    <= 1'b0;
      held_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      cand_row_reg <= cand_row_next;
      cand_col_reg <= cand_col_next;
      code_reg     <= code_next;
      valid_reg    <= valid_next;
      held_reg     <= held_next;
    end
  end

  // Outputs are registered on the edge entering EMIT so they are visible during EMIT.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cand_row_next = cand_row_reg;
    cand_col_next = cand_col_reg;
    code_next     = code_reg;
    valid_next    = 1'b0;
    held_next     = held_reg;
    col_advance   = 1'b0;
    case (state_reg)
      SCAN: if (sample) begin
        if (|single_low) begin
          cand_row_next = row_hit;
          cand_col_next = col_idx;
          cnt_next      = CNT_W'(1);
          state_next    = DEBOUNCE;
        end else begin
          col_advance = 1'b1;
        end
      end
      DEBOUNCE: if (sample) begin
        if (cand_match) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_next = EMIT;
            code_next  = encode_key(cand_row_reg, cand_col_reg);
            valid_next = 1'b1;
            held_next  = 1'b1;
          end
        end else begin
          cnt_next    = '0;
          state_next  = SCAN;
          col_advance = 1'b1;
        end
      end
      EMIT: begin
        cnt_next   = '0;
        state_next = RELEASE;
      end
      RELEASE: if (sample) begin
        if (row_n == 4'b1111) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            cnt_next    = '0;
            held_next   = 1'b0;
            state_next  = SCAN;
            col_advance = 1'b1;
          end
        end else begin
          cnt_next = '0;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  assign Code_1   = code_reg;
  assign Valid_1  = valid_reg;
  assign key_held = held_reg;

endmodule
